vid_pattern_gen: RTL and testbench

- Parametrised video pixel source with a valid/ready output stream, feeding the TMDS video controller's 24-bit pixel input or any pixel-stream consumer.
- Replaces the free-running pixel counter used in stimulus benches with a synthesizable generator.
- Provides four selectable patterns, per-frame mode latching, backpressure, and frame/line markers.

---
 rtl/vid_pkg.sv | 38 +++
 rtl/vid_pattern_gen_if.sv | 21 ++
 rtl/vid_xy_counter.sv | 83 ++++++++
 rtl/vid_pattern_gen.sv | 139 +++++++++++++
 tb/tb_vid_pattern_gen.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/vid_pkg.sv
// Shared types and constants for the video pattern generator.
// Bar masks are {R,G,B} on/off bits, expanded to full pixels by mask_to_pixel.
package vid_pkg;

    typedef enum logic [1:0] {
        PAT_RAMP  = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_mode_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } hs_state_e;

    localparam int MAX_COLOR_W = 16;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [2:0] BAR_MASK [8] = '{
        3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
    };

    function automatic logic [3*MAX_COLOR_W-1:0] mask_to_pixel(input logic [2:0] mask,
                                                              input int color_w);
        logic [3*MAX_COLOR_W-1:0] pix;
        pix = '0;
        for (int i = 0; i < MAX_COLOR_W; i++) begin
            if (i < color_w) begin
                pix[i]             = mask[0];
                pix[color_w + i]   = mask[1];
                pix[2*color_w + i] = mask[2];
            end
        end
        return pix;
    endfunction

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Pixel stream with valid/ready handshake and frame/line markers.
interface vid_pattern_gen_if #(
    parameter int DATA_W = 24
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              out_eof;

    modport master (
        output out_valid, out_data, out_sof, out_eol, out_eof,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_data, out_sof, out_eol, out_eof,
        output out_ready
    );
endinterface

// File: rtl/vid_xy_counter.sv
// Raster position counter: x/y plus colour-bar index, advanced one pixel per pulse.
// Outputs describe the position that will be emitted on the next advance.
module vid_xy_counter
    import vid_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [2:0]    bar_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          eof_o
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BAR_W - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bar_q, bar_d;
    logic          x_last, y_last;

    assign x_last = (x_q == X_LAST);
    assign y_last = (y_q == Y_LAST);

    // bcnt tracks the offset inside the current bar, so no divide by BAR_W is needed
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        bcnt_d = bcnt_q;
        bar_d  = bar_q;
        if (advance_i) begin
            if (x_last) begin
                x_d    = '0;
                bcnt_d = '0;
                bar_d  = '0;
                y_d    = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
                if (bcnt_q == B_LAST) begin
                    bcnt_d = '0;
                    bar_d  = bar_q + 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            bcnt_q <= '0;
            bar_q  <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            bcnt_q <= bcnt_d;
            bar_q  <= bar_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign bar_o = bar_q;
    assign sof_o = (x_q == '0) && (y_q == '0);
    assign eol_o = x_last;
    assign eof_o = x_last && y_last;

endmodule

// File: rtl/vid_pattern_gen.sv
// Video pattern source: ramp, colour bars, checkerboard or solid colour on a
// valid/ready pixel stream, with pattern selection latched once per frame.
//
//   state     | meaning
//   ST_IDLE   | no beat pending, out_valid low
//   ST_ACTIVE | beat held in output register, out_valid high
module vid_pattern_gen
    import vid_pkg::*;
#(
    parameter int COLOR_W    = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int CHECK_LOG2 = 5,
    parameter int FCNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_color,
    vid_pattern_gen_if.master      out_if,
    output logic [FCNT_W-1:0]      frame_cnt
);

    localparam int DATA_W = 3 * COLOR_W;
    localparam int XW     = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW     = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    hs_state_e         state_q, state_d;
    logic              load;
    logic              xfer;

    logic [XW-1:0]     pos_x;
    logic [YW-1:0]     pos_y;
    logic [2:0]        pos_bar;
    logic              pos_sof, pos_eol, pos_eof;

    pat_mode_e         mode_q, mode_sel;
    logic [DATA_W-1:0] solid_q, solid_sel;
    logic [DATA_W-1:0] ramp_q;
    logic [DATA_W-1:0] pix_d;
    logic              chk_x, chk_y;

    logic [DATA_W-1:0] data_q;
    logic              sof_q, eol_q, eof_q;
    logic [FCNT_W-1:0] fcnt_q;

    assign xfer = (state_q == ST_ACTIVE) && out_if.out_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_ACTIVE;
                    load    = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (xfer) begin
                    if (en) load = 1'b1;
                    else    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter points at the next pixel to load, so it advances on load.
    vid_xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_xy (
        .clk       (clk),
        .rst       (rst),
        .advance_i (load),
        .x_o       (pos_x),
        .y_o       (pos_y),
        .bar_o     (pos_bar),
        .sof_o     (pos_sof),
        .eol_o     (pos_eol),
        .eof_o     (pos_eof)
    );

    // Pixel (0,0) must already use the new selection, hence the bypass.
    assign mode_sel  = pos_sof ? pat_mode_e'(mode) : mode_q;
    assign solid_sel = pos_sof ? solid_color : solid_q;

    assign chk_x = |((pos_x >> CHECK_LOG2) & XW'(1));
    assign chk_y = |((pos_y >> CHECK_LOG2) & YW'(1));

    always_comb begin
        pix_d = '0;
        case (mode_sel)
            PAT_RAMP:  pix_d = ramp_q;
            PAT_BARS:  pix_d = DATA_W'(mask_to_pixel(BAR_MASK[pos_bar], COLOR_W));
            PAT_CHECK: pix_d = (chk_x ^ chk_y) ? '1 : '0;
            PAT_SOLID: pix_d = solid_sel;
            default:   pix_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            ramp_q  <= '0;
            mode_q  <= PAT_RAMP;
            solid_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                data_q <= pix_d;
                sof_q  <= pos_sof;
                eol_q  <= pos_eol;
                eof_q  <= pos_eof;
                ramp_q <= ramp_q + 1'b1;
                if (pos_sof) begin
                    mode_q  <= pat_mode_e'(mode);
                    solid_q <= solid_color;
                end
            end
            if (xfer && eof_q) fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign out_if.out_valid = (state_q == ST_ACTIVE);
    assign out_if.out_data  = data_q;
    assign out_if.out_sof   = sof_q;
    assign out_if.out_eol   = eol_q;
    assign out_if.out_eof   = eof_q;
    assign frame_cnt        = fcnt_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen with a 16x4 frame and 2-pixel checker squares.
module tb_vid_pattern_gen;

    localparam int CW = 8;
    localparam int DW = 24;
    localparam int H  = 16;
    localparam int V  = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] solid;
    logic [FW-1:0] frame_cnt;

    vid_pattern_gen_if #(.DATA_W(DW)) vif ();

    vid_pattern_gen #(
        .COLOR_W    (CW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .CHECK_LOG2 (1),
        .FCNT_W     (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .solid_color (solid),
        .out_if      (vif),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] bd;
    logic          bs, be, bf;

    logic [DW-1:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one beat with ready high; called and returns on a falling edge.
    task automatic take_beat();
        vif.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (vif.out_valid === 1'b1) begin
                bd = vif.out_data;
                bs = vif.out_sof;
                be = vif.out_eol;
                bf = vif.out_eof;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        total++;
        bad++;
        $error("FAIL beat_timeout observed=no_valid expected=valid_within_20");
        bd = 'x;
        bs = 1'bx;
        be = 1'bx;
        bf = 1'bx;
    endtask

    function automatic logic [DW-1:0] model(input int m, input int idx);
        int x, y;
        x = idx % H;
        y = (idx / H) % V;
        case (m)
            0:       return DW'(idx);
            1:       return bars[x / 2];
            2:       return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            default: return 24'h123456;
        endcase
    endfunction

    task automatic beat_check(input int m, input int idx);
        int p;
        p = idx % (H * V);
        take_beat();
        chk($sformatf("data[%0d]", idx), 64'(bd), 64'(model(m, idx)));
        chk($sformatf("sof[%0d]", idx),  64'(bs), 64'(p == 0));
        chk($sformatf("eol[%0d]", idx),  64'(be), 64'((p % H) == H - 1));
        chk($sformatf("eof[%0d]", idx),  64'(bf), 64'(p == H * V - 1));
    endtask

    initial begin
        int            exp_n;
        int            got;
        logic          pend;
        logic [DW-1:0] pend_d;
        logic          r;

        rst           = 1'b1;
        en            = 1'b1;
        mode          = 2'd0;
        solid         = '0;
        vif.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", 64'(vif.out_valid), 64'd0);
        chk("rst_data",  64'(vif.out_data),  64'd0);
        chk("rst_sof",   64'(vif.out_sof),   64'd0);
        chk("rst_eol",   64'(vif.out_eol),   64'd0);
        chk("rst_eof",   64'(vif.out_eof),   64'd0);
        chk("rst_fcnt",  64'(frame_cnt),     64'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("valid_latency", 64'(vif.out_valid), 64'd1);

        // frame 0: ramp
        for (int i = 0; i < 64; i++) beat_check(0, i);
        chk("fcnt_after_f0", 64'(frame_cnt), 64'd1);

        // frame 1: ramp, selection changes mid-frame and must wait
        for (int i = 64; i < 128; i++) begin
            if (i == 84) begin
                mode  = 2'd3;
                solid = 24'h123456;
            end
            beat_check(0, i);
        end
        chk("fcnt_after_f1", 64'(frame_cnt), 64'd2);

        // frame 2: solid
        beat_check(3, 128);
        mode = 2'd1;
        for (int i = 129; i < 192; i++) beat_check(3, i);

        // frame 3: colour bars
        beat_check(1, 192);
        mode = 2'd2;
        for (int i = 193; i < 256; i++) beat_check(1, i);

        // frame 4: checkerboard, interrupted by reset at pixel 37
        for (int i = 256; i < 256 + 37; i++) beat_check(2, i);
        chk("fcnt_in_f4", 64'(frame_cnt), 64'd4);

        rst  = 1'b1;
        mode = 2'd0;
        @(negedge clk);
        chk("midrst_valid", 64'(vif.out_valid), 64'd0);
        chk("midrst_fcnt",  64'(frame_cnt),     64'd0);
        rst = 1'b0;
        beat_check(0, 0);
        chk("postrst_fcnt", 64'(frame_cnt), 64'd0);

        // backpressure with random ready
        exp_n = 1;
        got   = 0;
        pend  = 1'b0;
        pend_d = '0;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            r = 1'($urandom_range(0, 1));
            vif.out_ready = r;
            if (pend) begin
                chk("stall_valid", 64'(vif.out_valid), 64'd1);
                chk("stall_data",  64'(vif.out_data),  64'(pend_d));
            end
            if (vif.out_valid === 1'b1) begin
                if (r) begin
                    chk($sformatf("bp_data[%0d]", exp_n), 64'(vif.out_data), 64'(DW'(exp_n)));
                    exp_n++;
                    got++;
                    pend = 1'b0;
                end else begin
                    pend   = 1'b1;
                    pend_d = vif.out_data;
                end
            end else begin
                pend = 1'b0;
            end
            @(negedge clk);
        end
        chk("bp_count", 64'(got), 64'd100);

        // pause and resume
        en = 1'b0;
        beat_check(0, exp_n);
        exp_n++;
        chk("pause_valid_now", 64'(vif.out_valid), 64'd0);
        repeat (3) @(negedge clk);
        chk("pause_valid_held", 64'(vif.out_valid), 64'd0);
        en = 1'b1;
        beat_check(0, exp_n);
        exp_n++;
        beat_check(0, exp_n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
